// File: rtl/mul_pipe.sv
// mul_pipe: pipelined join-multiplier with valid/ready handshakes.
//
// One operand pair is consumed only when din0 and din1 are both valid and
// stage 1 can accept. The full-width product (DIN0+DIN1 bits) appears on
// dout after STAGES register stages. Each operand is sign- or zero-extended
// to the product width per its *_SIGNED parameter, so the truncated product
// is exact for every signedness mix. STAGES = 0 gives a purely combinational
// join-multiply.
//
// Ports:
//   clk           clock, rising edge
//   rst           asynchronous reset, active-low
//   din0_data_i   operand A             din0_valid_i / din0_ready_o
//   din1_data_i   operand B             din1_valid_i / din1_ready_o
//   dout_data_o   product, DIN0+DIN1 b  dout_valid_o / dout_ready_i
module mul_pipe #(
   parameter int DIN0        = 16,
   parameter int DIN1        = 16,
   parameter int DIN0_SIGNED = 0,
   parameter int DIN1_SIGNED = 0,
   parameter int STAGES      = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DIN0-1:0]      din0_data_i,
   input  logic                 din0_valid_i,
   output logic                 din0_ready_o,
   input  logic [DIN1-1:0]      din1_data_i,
   input  logic                 din1_valid_i,
   output logic                 din1_ready_o,
   output logic [DIN0+DIN1-1:0] dout_data_o,
   output logic                 dout_valid_o,
   input  logic                 dout_ready_i
);

   localparam int P = DIN0 + DIN1;

   logic [P-1:0] a_ext;
   logic [P-1:0] b_ext;
   logic [P-1:0] prod;
   logic         pair_valid;

   // Extending both operands to P bits makes a plain P-bit multiply exact
   // modulo 2^P regardless of which operands are two's complement.
   generate
      if (DIN0_SIGNED != 0) begin : g_a_signed
         assign a_ext = {{DIN1{din0_data_i[DIN0-1]}}, din0_data_i};
      end else begin : g_a_unsigned
         assign a_ext = {{DIN1{1'b0}}, din0_data_i};
      end
      if (DIN1_SIGNED != 0) begin : g_b_signed
         assign b_ext = {{DIN0{din1_data_i[DIN1-1]}}, din1_data_i};
      end else begin : g_b_unsigned
         assign b_ext = {{DIN0{1'b0}}, din1_data_i};
      end
   endgenerate

   assign prod       = a_ext * b_ext;
   assign pair_valid = din0_valid_i & din1_valid_i;

   generate
      if (STAGES == 0) begin : g_comb
         // No state: clock and reset are intentionally unconnected.
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;

         assign dout_valid_o = pair_valid;
         assign dout_data_o  = prod;
         assign din0_ready_o = pair_valid & dout_ready_i;
         assign din1_ready_o = pair_valid & dout_ready_i;
      end else begin : g_pipe
         logic [STAGES:1] v_q;
         logic [STAGES:1] v_d;
         logic [P-1:0]    d_q [1:STAGES];
         logic [P-1:0]    d_d [1:STAGES];
         logic [STAGES:1] en;
         logic [STAGES:0] vs;
         logic [P-1:0]    ds  [0:STAGES];
         logic            fire_in;

         // Stage k loads when it is empty or everything downstream of it
         // moves; walking from the output back gives that as a running OR.
         always_comb begin
            logic acc;
            acc = dout_ready_i;
            en  = '0;
            for (int k = STAGES; k >= 1; k--) begin
               acc   = !v_q[k] | acc;
               en[k] = acc;
            end
         end

         // Index 0 is the unregistered input pair, 1..STAGES the registers.
         always_comb begin
            vs    = {v_q, pair_valid};
            ds[0] = prod;
            for (int k = 1; k <= STAGES; k++) begin
               ds[k] = d_q[k];
            end
         end

         always_comb begin
            v_d = v_q;
            for (int k = 1; k <= STAGES; k++) begin
               d_d[k] = d_q[k];
               if (en[k]) begin
                  v_d[k] = vs[k-1];
                  d_d[k] = ds[k-1];
               end
            end
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               v_q <= '0;
               for (int k = 1; k <= STAGES; k++) begin
                  d_q[k] <= '0;
               end
            end else begin
               v_q <= v_d;
               d_q <= d_d;
            end
         end

         // Ready is forced low while reset is held, independent of the en chain.
         assign fire_in      = pair_valid & en[1] & rst;
         assign din0_ready_o = fire_in;
         assign din1_ready_o = fire_in;
         assign dout_valid_o = v_q[STAGES];
         assign dout_data_o  = d_q[STAGES];
      end
   endgenerate

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Pipelined, parametrised-latency multiplier with DTI handshakes on all ports.
- Joins din0 and din1: one operand pair is consumed only when both are valid. Emits the full-width product after STAGES register stages.
- Sits in datapaths that need a timing-closed multiply. Supports per-input signedness, full backpressure and bubble collapsing.

Parameters:
- DIN0, 16, width of din0.data in bits (1..64)
- DIN1, 16, width of din1.data in bits (1..64)
- DIN0_SIGNED, 0, 1 = din0.data is two's complement
- DIN1_SIGNED, 0, 1 = din1.data is two's complement
- STAGES, 2, number of pipeline register stages (0..8); 0 = purely combinational join-multiply

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- din0  dti.consumer  DIN0  operand A (data, valid, ready)
- din1  dti.consumer  DIN1  operand B (data, valid, ready)
- dout  dti.producer  DIN0+DIN1  product (data, valid, ready)

Behaviour:
- Width: product width P = DIN0+DIN1. Each operand is sign- or zero-extended to P per its *_SIGNED parameter, then multiplied mod 2^P. The result is exact for all operand values, including mixed signedness; e.g. 8b signed -1 times 8b unsigned 255 gives 16'hFF01.
- Input join: fire_in = din0.valid & din1.valid & en[1].
  - din0.ready = din1.ready = fire_in.
  - Neither input is acknowledged alone; a valid operand waits for its partner.
- Pipeline: stage k (1..STAGES) holds v[k] and d[k].
  - en[STAGES+1] = dout.ready.
  - en[k] = !v[k] | en[k+1] (bubble collapsing: an empty stage always accepts).
- Stage update when en[k]:
  - v[k] <= v[k-1], d[k] <= d[k-1], with v[0] = din0.valid & din1.valid and d[0] = product.
  - When !en[k], the stage holds.
  - The multiplier may be split or retimed across stages; only the data visible at dout is specified.
- Output: dout.valid = v[STAGES], dout.data = d[STAGES].
- Latency: exactly STAGES cycles from input handshake to dout.valid when never stalled.
- Throughput: one product per cycle while dout.ready = 1.
- Backpressure:
  - While dout.ready = 0, dout.valid and dout.data are held stable.
  - Upstream stages keep filling until every stage is valid; then din ready drops.
  - Capacity when fully stalled = STAGES entries.
- STAGES = 0:
  - dout.valid = din0.valid & din1.valid, dout.data = combinational product.
  - din ready = dout.valid & dout.ready.
  - No registers; clk and rst are unused.
- Ordering: products leave strictly in acceptance order. No drop, no duplication.
- Reset:
  - While rst = 0, asynchronously v[*] = 0, d[*] = 0, dout.valid = 0, dout.data = 0, din ready = 0.
  - Reset mid-operation discards all in-flight products.
  - The first cycle after release behaves as an empty pipe.
- Simultaneous events: in one cycle, dout may retire the head while an input pair enters the tail and all middle stages shift. No bubble is inserted and no beat is lost.
- dout.valid never depends combinationally on dout.ready.
- din ready depends on dout.ready only through the en chain.

Test Plan:
- Unsigned stream: DIN0 = DIN1 = 8, STAGES = 2, dout.ready = 1; pairs (3,5), (255,255), (0,7) on consecutive cycles -> dout 15, 65025, 0 on cycles 2, 3, 4 after the first handshake, dout.valid high for 3 consecutive cycles.
- Signedness: DIN0 = DIN1 = 8, all four *_SIGNED combos; operands (8'hFF, 8'hFF) -> 16'hFE01 (uu), 16'hFF01 (su), 16'hFF01 (us), 16'h0001 (ss).
- Join: din0.valid high with 4 and held for 3 cycles before din1.valid rises with 6 -> no ready on either until both are valid. Exactly one handshake; dout = 24 after STAGES cycles.
- Backpressure: STAGES = 3, dout.ready = 0 while issuing 5 pairs -> exactly 3 accepted, then din ready low. dout.data stable while stalled. On ready = 1 all products drain in order, then the 2 remaining pairs are accepted.
- Bubbles: random valid/ready toggling for 10k beats, all parameter corners (STAGES 0, 1, 4; widths 1 and 33) -> scoreboard matches the reference product in order, with no loss or duplication.
- Reset mid-flight: rst = 0 for 1 cycle with 2 products in the pipe -> dout.valid = 0 immediately (async). No stale product appears after release, and the next pair completes with correct latency.
